// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - frame geometry, pixel type and capture state shared by capture and scan-out
package camera_pkg;
  localparam int H_PIXELS    = 640;
  localparam int V_LINES     = 480;
  localparam int FRAME_WORDS = H_PIXELS * V_LINES;
  localparam int ADDR_W      = 19;
  localparam int SYNC_STAGES = 2;

  typedef logic [11:0] pixel_t;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } cap_state_t;
endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - multi-flop synchroniser with rise/fall detection on the synchronised level
module cam_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB444 byte-pair capture into the frame RAM write port
module ov7670_capture #(
  parameter int H_PIXELS    = camera_pkg::H_PIXELS,
  parameter int V_LINES     = camera_pkg::V_LINES,
  parameter int ADDR_W      = camera_pkg::ADDR_W,
  parameter int SYNC_STAGES = camera_pkg::SYNC_STAGES
) (
  input  logic               clk25,
  input  logic               rst_n,
  input  logic               cam_pclk,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_data,
  output logic [ADDR_W-1:0]  frame_addr,
  output camera_pkg::pixel_t frame_pixel,
  output logic               frame_we,
  output logic               frame_done,
  output logic               frame_err
);
  import camera_pkg::*;

  localparam int              LW    = $clog2(V_LINES + 1);
  localparam int              PW    = $clog2(H_PIXELS + 1);
  localparam logic [ADDR_W:0] FW_W  = (ADDR_W+1)'(H_PIXELS * V_LINES);
  localparam logic [LW-1:0]   V_CNT = LW'(V_LINES);
  localparam logic [PW-1:0]   H_CNT = PW'(H_PIXELS);

  logic w_pclk_level, w_pclk_rise, w_pclk_fall;
  logic w_vs_level, w_vs_rise, w_vs_fall;
  logic w_href, w_href_rise, w_href_fall;
  logic w_unused;
  logic [7:0] w_data;
  logic [ADDR_W:0] w_written;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_pclk (
    .i_clk(clk25), .i_rst_n(rst_n), .i_d(cam_pclk),
    .o_level(w_pclk_level), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
  );
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_vsync (
    .i_clk(clk25), .i_rst_n(rst_n), .i_d(cam_vsync),
    .o_level(w_vs_level), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
  );
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_href (
    .i_clk(clk25), .i_rst_n(rst_n), .i_d(cam_href),
    .o_level(w_href), .o_rise(w_href_rise), .o_fall(w_href_fall)
  );

  assign w_unused = &{w_pclk_level, w_pclk_fall, w_vs_level, w_href_rise};

  // Data gets the same depth as pclk so the byte lines up with its edge.
  logic [7:0] r_data_dly [SYNC_STAGES];
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_data_dly[i] <= '0;
    end else begin
      r_data_dly[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) r_data_dly[i] <= r_data_dly[i-1];
    end
  end
  assign w_data = r_data_dly[SYNC_STAGES-1];

  cap_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  pixel_t            r_pixel;
  logic              r_we, r_done, r_err, r_phase, r_bad_line, r_ovf;
  logic [3:0]        r_byte0;
  logic [LW-1:0]     r_line_cnt;
  logic [PW-1:0]     r_pix_cnt;

  // A write still in flight has not yet advanced the address.
  assign w_written = {1'b0, r_addr} + {{ADDR_W{1'b0}}, r_we};

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_FRAME;
      r_addr     <= '0;
      r_pixel    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_phase    <= 1'b0;
      r_byte0    <= '0;
      r_line_cnt <= '0;
      r_pix_cnt  <= '0;
      r_bad_line <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      if (r_we) r_addr <= r_addr + 1'b1;
      case (r_state)
        WAIT_FRAME: begin
          if (w_vs_fall) begin
            r_state    <= ACTIVE;
            r_addr     <= '0;
            r_phase    <= 1'b0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_bad_line <= 1'b0;
            r_ovf      <= 1'b0;
          end
        end
        ACTIVE: begin
          if (w_vs_rise) begin
            r_state <= WAIT_FRAME;
            r_done  <= 1'b1;
            r_err   <= (w_written != FW_W) || (r_line_cnt != V_CNT) || r_bad_line || r_ovf;
          end else if (w_href_fall) begin
            r_phase   <= 1'b0;
            r_pix_cnt <= '0;
            if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
            if (r_pix_cnt != H_CNT) r_bad_line <= 1'b1;
          end else if (w_pclk_rise && w_href) begin
            if (!r_phase) begin
              r_byte0 <= w_data[3:0];
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_pix_cnt != '1) r_pix_cnt <= r_pix_cnt + 1'b1;
              if ({1'b0, r_addr} == FW_W) begin
                r_ovf <= 1'b1;
              end else begin
                r_pixel <= {r_byte0, w_data};
                r_we    <= 1'b1;
              end
            end
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  assign frame_addr  = r_addr;
  assign frame_pixel = r_pixel;
  assign frame_we    = r_we;
  assign frame_done  = r_done;
  assign frame_err   = r_err;
endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized frame stimulus checked against a frame-level capture model
module tb_ov7670_capture;
  import camera_pkg::*;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int AW = 6;
  localparam int SS = 2;
  localparam int FW = H * V;

  logic          clk25 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [AW-1:0] frame_addr;
  pixel_t        frame_pixel;
  logic          frame_we, frame_done, frame_err;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk25(clk25), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .frame_addr(frame_addr),
    .frame_pixel(frame_pixel), .frame_we(frame_we), .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk25 = ~clk25;

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  int exp_pix_q[$];
  int exp_err_q[$];
  int n_we = 0;
  int n_abc = 0;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  int prev_addr = 0;

  int m_pix_total = 0;
  int m_lines = 0;
  int m_line_pix = 0;
  bit m_bad = 1'b0;
  bit m_capturing = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk25) begin
    if (prev_we) chk("addr_inc", int'(frame_addr), prev_addr + 1);
    if (frame_we) begin
      n_we++;
      if (frame_pixel == 12'hABC) n_abc++;
      chk("we_pending", int'(exp_addr_q.size() > 0), 1);
      if (exp_addr_q.size() > 0) begin
        chk("we_addr", int'(frame_addr), exp_addr_q.pop_front());
        chk("we_pixel", int'(frame_pixel), exp_pix_q.pop_front());
      end
      chk("we_single", int'(prev_we), 0);
    end
    if (frame_done) begin
      chk("done_pending", int'(exp_err_q.size() > 0), 1);
      if (exp_err_q.size() > 0) chk("frame_err", int'(frame_err), exp_err_q.pop_front());
      chk("done_single", int'(prev_done), 0);
    end
    prev_we   = frame_we;
    prev_done = frame_done;
    prev_addr = int'(frame_addr);
  end

  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk25);
    cam_pclk = 1'b0;
    cam_data = b;
    repeat (2) @(negedge clk25);
    cam_pclk = 1'b1;
    @(negedge clk25);
  endtask

  // Every second byte of a line completes a pixel; pixels past the frame size are dropped.
  task automatic send_bytes(input int n, input int mode);
    logic [7:0] b;
    logic [7:0] b0;
    b0 = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) b = (i % 2 == 0) ? 8'h0A : 8'hBC;
      else b = 8'($urandom);
      if (i % 2 == 0) b0 = b;
      else if (m_capturing) begin
        if (m_pix_total < FW) begin
          exp_addr_q.push_back(m_pix_total);
          exp_pix_q.push_back(int'({b0[3:0], b}));
        end
        m_pix_total++;
        m_line_pix++;
      end
      cam_byte(b);
    end
  endtask

  task automatic line_end();
    @(negedge clk25);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (12) @(negedge clk25);
    if (m_capturing) begin
      m_lines++;
      if (m_line_pix != H) m_bad = 1'b1;
    end
    m_line_pix = 0;
  endtask

  task automatic do_line(input int n, input int mode);
    cam_href = 1'b1;
    send_bytes(n, mode);
    line_end();
  endtask

  task automatic frame_begin();
    @(negedge clk25);
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk25);
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk25);
    m_pix_total = 0;
    m_lines = 0;
    m_line_pix = 0;
    m_bad = 1'b0;
    m_capturing = 1'b1;
  endtask

  function automatic int model_err();
    return int'(m_pix_total != FW || m_lines != V || m_bad);
  endfunction

  task automatic frame_end();
    @(negedge clk25);
    cam_vsync = 1'b1;
    if (m_capturing) exp_err_q.push_back(model_err());
    m_capturing = 1'b0;
    repeat (10) @(negedge clk25);
  endtask

  initial begin
    int we0, abc0, nl, k, n;

    // Reset state, then release mid-line while vsync is low.
    repeat (3) @(negedge clk25);
    chk("rst_addr", int'(frame_addr), 0);
    chk("rst_pixel", int'(frame_pixel), 0);
    chk("rst_we", int'(frame_we), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(frame_err), 0);
    we0 = n_we;
    cam_href = 1'b1;
    send_bytes(3, 0);
    rst_n = 1'b1;
    send_bytes(6, 0);
    line_end();
    do_line(2*H, 0);
    do_line(2*H, 0);
    chk("midstart_no_we", n_we - we0, 0);

    // Full frame of constant 0x0A,0xBC pairs.
    we0 = n_we; abc0 = n_abc;
    frame_begin();
    for (int l = 0; l < V; l++) do_line(2*H, 1);
    frame_end();
    chk("full_we", n_we - we0, 48);
    chk("full_abc", n_abc - abc0, 48);
    chk("full_err", int'(frame_err), 0);
    chk("full_addr", int'(frame_addr), 48);

    // Odd trailing byte on line 1, short line 5.
    we0 = n_we;
    frame_begin();
    for (int l = 0; l < V; l++) do_line((l == 1) ? 2*H+1 : (l == 5) ? 2*H-2 : 2*H, 0);
    frame_end();
    chk("odd_we", n_we - we0, 47);
    chk("odd_err", int'(frame_err), 1);

    // Overflow by one line.
    we0 = n_we;
    frame_begin();
    for (int l = 0; l < V + 1; l++) do_line(2*H, 0);
    frame_end();
    chk("ovf_we", n_we - we0, 48);
    chk("ovf_addr", int'(frame_addr), 48);
    chk("ovf_err", int'(frame_err), 1);

    // Clean random-data frame.
    frame_begin();
    for (int l = 0; l < V; l++) do_line(2*H, 0);
    frame_end();
    chk("rand_err", int'(frame_err), 0);

    // Async reset in the middle of line 2, pixel 3.
    frame_begin();
    do_line(2*H, 0);
    do_line(2*H, 0);
    cam_href = 1'b1;
    send_bytes(7, 0);
    repeat (3) @(negedge clk25);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_drained", exp_addr_q.size(), 0);
    chk("mid_rst_addr", int'(frame_addr), 0);
    chk("mid_rst_pixel", int'(frame_pixel), 0);
    chk("mid_rst_we", int'(frame_we), 0);
    chk("mid_rst_done", int'(frame_done), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    m_capturing = 1'b0;
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;
    we0 = n_we;
    send_bytes(9, 0);
    line_end();
    do_line(2*H, 0);
    frame_end();
    chk("post_rst_no_we", n_we - we0, 0);
    frame_begin();
    for (int l = 0; l < V; l++) do_line(2*H, 0);
    frame_end();
    chk("post_rst_err", int'(frame_err), 0);

    // Random line lengths and line counts.
    for (int f = 0; f < 4; f++) begin
      frame_begin();
      nl = V - 1 + int'($urandom_range(0, 2));
      for (int l = 0; l < nl; l++) begin
        k = int'($urandom_range(0, 5));
        case (k)
          0: n = 2*H - 2;
          1: n = 2*H + 1;
          2: n = 2*H - 1;
          default: n = 2*H;
        endcase
        do_line(n, 0);
      end
      frame_end();
    end

    // vsync rise coincides with the second byte's pclk edge.
    we0 = n_we;
    frame_begin();
    for (int l = 0; l < V; l++) do_line(2*H, 0);
    cam_href = 1'b1;
    send_bytes(1, 0);
    @(negedge clk25);
    cam_pclk = 1'b0;
    cam_data = 8'h5A;
    repeat (2) @(negedge clk25);
    exp_err_q.push_back(model_err());
    m_capturing = 1'b0;
    cam_pclk = 1'b1;
    cam_vsync = 1'b1;
    repeat (4) @(negedge clk25);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (12) @(negedge clk25);
    chk("simul_we", n_we - we0, 48);
    chk("simul_err", int'(frame_err), 0);

    chk("writes_left", exp_addr_q.size(), 0);
    chk("dones_left", exp_err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
